// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: MA priority with ALU aging, registered RF write.
// Optional WB_FWD_EN adds same-cycle forwarding outputs.
module wb_port_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ma_valid,
  output logic              ma_ready,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_src,
`ifdef WB_FWD_EN
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [3:0]        alu_wait
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic starve;
  logic alu_xfer;
  logic ma_xfer;

  assign starve    = (alu_wait == WAIT_MAX);
  assign ma_ready  = !(alu_valid && starve);
  assign alu_ready = !ma_valid || starve;
  assign alu_xfer  = alu_valid && alu_ready;
  assign ma_xfer   = ma_valid && ma_ready;

  // ALU aging: count consecutive lost cycles, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_wait <= '0;
    end else if (!alu_valid || alu_xfer) begin
      alu_wait <= '0;
    end else if (alu_wait != WAIT_MAX) begin
      alu_wait <= alu_wait + 4'd1;
    end
  end

  // Register the winning transfer onto the RF write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      rf_src  <= 1'b0;
    end else begin
      rf_we <= alu_xfer || ma_xfer;
      unique case (1'b1)
        alu_xfer: begin
          rf_addr <= alu_addr;
          rf_data <= alu_data;
          rf_src  <= 1'b1;
        end
        ma_xfer: begin
          rf_addr <= ma_addr;
          rf_data <= ma_data;
          rf_src  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef WB_FWD_EN
  // Same-cycle bypass copy of the winning transfer
  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    unique case (1'b1)
      alu_xfer: begin
        fwd_valid = rst_n;
        fwd_addr  = alu_addr;
        fwd_data  = alu_data;
      end
      ma_xfer: begin
        fwd_valid = rst_n;
        fwd_addr  = ma_addr;
        fwd_data  = ma_data;
      end
      default: ;
    endcase
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: behavioural model plus
// directed vectors with literal expectations.
module tb_wb_port_arbiter;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] alu_data = '0;
  logic          ma_valid = 1'b0;
  logic          ma_ready;
  logic [AW-1:0] ma_addr = '0;
  logic [DW-1:0] ma_data = '0;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          rf_src;
  logic [3:0]    alu_wait;
`ifdef WB_FWD_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_addr(alu_addr), .alu_data(alu_data),
    .ma_valid(ma_valid), .ma_ready(ma_ready),
    .ma_addr(ma_addr), .ma_data(ma_data),
    .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_data(rf_data), .rf_src(rf_src),
`ifdef WB_FWD_EN
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data),
`endif
    .alu_wait(alu_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the ALU has lost m_lost cycles in a row while requesting
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_src;
  int            m_lost;

  function automatic bit alu_wins();
    return alu_valid && (!ma_valid || m_lost == MW);
  endfunction

  function automatic bit ma_wins();
    return ma_valid && !alu_wins();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_we   <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      m_src  <= 1'b0;
      m_lost <= 0;
    end else begin
      m_we <= alu_wins() || ma_wins();
      if (alu_wins()) begin
        m_addr <= alu_addr;
        m_data <= alu_data;
        m_src  <= 1'b1;
      end else if (ma_wins()) begin
        m_addr <= ma_addr;
        m_data <= ma_data;
        m_src  <= 1'b0;
      end
      if (alu_valid && !alu_wins())
        m_lost <= (m_lost < MW) ? m_lost + 1 : MW;
      else
        m_lost <= 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.rf_we", rf_we, m_we);
      chk("m.rf_addr", rf_addr, m_addr);
      chk("m.rf_data", rf_data, m_data);
      chk("m.rf_src", rf_src, m_src);
      chk("m.alu_wait", alu_wait, m_lost);
      chk("m.alu_ready", alu_ready, !ma_valid || m_lost == MW);
      chk("m.ma_ready", ma_ready, !(alu_valid && m_lost == MW));
`ifdef WB_FWD_EN
      chk("m.fwd_valid", fwd_valid, alu_wins() || ma_wins());
      if (alu_wins() || ma_wins()) begin
        chk("m.fwd_addr", fwd_addr,
            alu_wins() ? alu_addr : ma_addr);
        chk("m.fwd_data", fwd_data,
            alu_wins() ? alu_data : ma_data);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] wseq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0};
  logic       sseq [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    // Power-on reset
    #12;
    chk("rst.rf_we", rf_we, 0);
    chk("rst.rf_addr", rf_addr, 0);
    chk("rst.rf_data", rf_data, 0);
    chk("rst.alu_wait", alu_wait, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst.rf_we", rf_we, 0);

    // Single ALU request
    tick();
    alu_valid = 1; alu_addr = 5; alu_data = 8;
    @(negedge clk);
    chk("alu1.ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    @(negedge clk);
    chk("alu1.we", rf_we, 1);
    chk("alu1.addr", rf_addr, 5);
    chk("alu1.data", rf_data, 8);
    chk("alu1.src", rf_src, 1);
    tick();
    @(negedge clk);
    chk("alu1.we_off", rf_we, 0);
    chk("alu1.addr_hold", rf_addr, 5);
    chk("alu1.data_hold", rf_data, 8);

    // Aging: MA held 6 cycles, ALU held until it wins
    tick();
    ma_valid = 1; ma_addr = 5; ma_data = 11;
    alu_valid = 1; alu_addr = 3; alu_data = 14;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("age.wait", alu_wait, wseq[k]);
      if (k > 0) chk("age.src", rf_src, sseq[k-1]);
      tick();
      if (k == 3) alu_valid = 0;
    end
    ma_valid = 0;
    @(negedge clk);
    chk("age.src_last", rf_src, sseq[5]);
    chk("age.we_last", rf_we, 1);

    // Same address from both sources
    tick();
    ma_valid = 1; ma_addr = 7; ma_data = 11;
    alu_valid = 1; alu_addr = 7; alu_data = 14;
    tick();
    ma_valid = 0;
    @(negedge clk);
    chk("same.addr0", rf_addr, 7);
    chk("same.data0", rf_data, 11);
    chk("same.src0", rf_src, 0);
    tick();
    alu_valid = 0;
    @(negedge clk);
    chk("same.addr1", rf_addr, 7);
    chk("same.data1", rf_data, 14);
    chk("same.src1", rf_src, 1);
    tick();

    // Idle
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k > 0) chk("idle.we", rf_we, 0);
      chk("idle.alu_ready", alu_ready, 1);
      chk("idle.ma_ready", ma_ready, 1);
      chk("idle.wait", alu_wait, 0);
    end

`ifdef WB_FWD_EN
    // Forwarding of a single MA request
    tick();
    ma_valid = 1; ma_addr = 2; ma_data = 9;
    @(negedge clk);
    chk("fwd.valid", fwd_valid, 1);
    chk("fwd.addr", fwd_addr, 2);
    chk("fwd.data", fwd_data, 9);
    tick();
    ma_valid = 0;
    @(negedge clk);
    chk("fwd.rf_addr", rf_addr, 2);
    chk("fwd.rf_data", rf_data, 9);
    chk("fwd.idle", fwd_valid, 0);
`endif

    // Reset mid-stream while both request
    tick();
    ma_valid = 1; ma_addr = 9; ma_data = 33;
    alu_valid = 1; alu_addr = 4; alu_data = 21;
    tick();
    tick();
    @(negedge clk);
    chk("mid.pre_wait", alu_wait, 2);
    chk("mid.pre_addr", rf_addr, 9);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid.rf_we", rf_we, 0);
    chk("mid.rf_addr", rf_addr, 0);
    chk("mid.rf_data", rf_data, 0);
    chk("mid.rf_src", rf_src, 0);
    chk("mid.wait", alu_wait, 0);
    ma_valid = 0;
    alu_valid = 0;
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("mid.post_we", rf_we, 0);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the two write-back sources: the ALU result path and the memory-access (MA) load path.
- Arbitrates per cycle using fixed MA priority with ALU anti-starvation aging.
- Registers the winning write and drives the register-file write port.
- Sits between the execute/memory stages and the register-file write interface, downstream of register_write-style value selection.

Parameters:
- DATA_W, 64: width of write-back value.
- ADDR_W, 4: register address width (16 registers).
- MAX_WAIT, 3: consecutive lost cycles after which a pending ALU request wins; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU write-back request
- alu_ready  output  1  ALU request accepted this cycle
- alu_addr  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU value
- ma_valid  input  1  MA write-back request
- ma_ready  output  1  MA request accepted this cycle
- ma_addr  input  ADDR_W  MA destination register
- ma_data  input  DATA_W  MA value
- rf_we  output  1  register-file write enable, registered
- rf_addr  output  ADDR_W  register address to be written, registered
- rf_data  output  DATA_W  final value to be written, registered
- rf_src  output  1  source of last write: 1 = ALU, 0 = MA (same sense as the write-back MUX select)
- alu_wait  output  4  current ALU aging count, for debug/verification

Behaviour:
- Reset: clock is clk; reset is rst_n, asynchronous and active-low.
  - While rst_n = 0: rf_we = 0, rf_addr = 0, rf_data = 0, rf_src = 0, alu_wait = 0.
  - Reset mid-operation discards any pending request; requesters re-present after release.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - Once raised, a requester holds valid, addr and data stable until its transfer. The arbiter does not buffer.
  - At most one transfer per cycle.
- starve = (alu_wait == MAX_WAIT).
- Ready logic, combinational, no dependence on own valid:
  - ma_ready = !(alu_valid && starve)
  - alu_ready = !ma_valid || starve
- Grant outcomes:
  - Only one requester valid: it wins immediately.
  - Both valid: MA wins unless starve, in which case ALU wins.
- Aging counter alu_wait:
  - Increments, saturating at MAX_WAIT, on each edge with alu_valid && !alu_ready.
  - Clears to 0 on an ALU transfer or when alu_valid = 0.
- Latency: exactly 1 cycle.
  - The winner's addr/data/source appear on rf_addr/rf_data/rf_src with rf_we = 1 on the edge after the transfer.
  - No transfer: rf_we = 0 next cycle; rf_addr/rf_data/rf_src hold their previous values.
- Both requesters targeting the same address: two separate writes in grant order; no merging. The later write determines the final register value.
- Back-to-back writes from the same source are allowed every cycle (full throughput).
- No address filtering; address 0 is written like any other.

Optional Feature:
- WB_FWD_EN defined:
  - Adds outputs fwd_valid (1), fwd_addr (ADDR_W), fwd_data (DATA_W).
  - These are combinational copies of the winning transfer in the current cycle, for same-cycle bypass to decode/execute.
  - fwd_valid = 0 when no transfer or while rst_n = 0.
- WB_FWD_EN not defined: these ports do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n = 0 mid-stream while alu_valid = 1 → rf_we/rf_addr/rf_data/rf_src/alu_wait all 0 immediately, without waiting for a clock edge; after release with no valid, rf_we stays 0.
- Single ALU: alu_valid = 1, alu_addr = 5, alu_data = 8 for one cycle → alu_ready = 1; next cycle rf_we = 1, rf_addr = 5, rf_data = 8, rf_src = 1; following cycle rf_we = 0, rf_addr/rf_data held.
- Aging (MAX_WAIT = 3): ma_valid held 6 cycles with addr 5/data 11; alu_valid held with addr 3/data 14 →
  - grants MA, MA, MA, ALU, MA, MA;
  - alu_wait sequence 0, 1, 2, 3, then 0 after the ALU transfer;
  - rf_src sequence 0, 0, 0, 1, 0, 0, each one cycle late.
- Same address: both valid with addr 7, MA data 11, ALU data 14, wait = 0 → rf writes 7/11 (src 0), then 7/14 (src 1) on consecutive cycles.
- Idle: no valid for 10 cycles → rf_we = 0 throughout, both readys = 1, alu_wait = 0.
- WB_FWD_EN: single MA request with addr 2, data 9 → fwd_valid = 1, fwd_addr = 2, fwd_data = 9 in the same cycle; rf_* update on the next edge; fwd_valid = 0 when idle.
